// File: rtl/remainder_scheduler_pkg.sv
// remainder_scheduler_pkg: shared state encoding and default
// widths for the remainder scheduler slice.
package remainder_scheduler_pkg;

  localparam int DEF_W = 20;
  localparam int CNTW  = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/remainder_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first
// request at or after ptr, wrapping modulo NREQ.
module rr_arbiter
  import remainder_scheduler_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);

  logic           hit;
  logic [IDW-1:0] j;

  always_comb begin
    gnt = '0;
    idx = '0;
    hit = 1'b0;
    j   = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = IDW'((int'(ptr) + i) % NREQ);
      if (en && !hit && req[j]) begin
        hit    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/remainder_scheduler.sv
// remainder_scheduler: round-robin front end time-sharing one
// registered remainder datapath among NREQ requesters.
module remainder_scheduler
  import remainder_scheduler_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = DEF_W,
  parameter int LAT  = 1,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_dividend,
  input  logic [NREQ*W-1:0] req_divisor,
  output logic [W-1:0]      dp_dividend,
  output logic [W-1:0]      dp_divisor,
  output logic              dp_start,
  input  logic [W-1:0]      dp_remainder,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_remainder,
  output logic              rsp_divzero
);

  state_t            state_q, state_d;
  logic [IDW-1:0]    ptr_q;
  logic [IDW-1:0]    idx;
  logic [NREQ-1:0]   gnt;
  logic [CNTW-1:0]   cnt_q;
  logic [W-1:0]      sel_dd, sel_ds;
  logic              grant;

  rr_arbiter #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_arb (
    .req(req_valid),
    .ptr(ptr_q),
    .en (state_q == S_IDLE),
    .gnt(gnt),
    .idx(idx)
  );

  assign sel_dd    = req_dividend[int'(idx)*W +: W];
  assign sel_ds    = req_divisor[int'(idx)*W +: W];
  assign grant     = |gnt;
  assign req_ready = gnt;
  assign dp_start  = (state_q == S_ISSUE);
  assign rsp_valid = (state_q == S_RESP);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (grant) state_d = (sel_ds == '0) ? S_RESP : S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (cnt_q == '0) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      cnt_q         <= '0;
      dp_dividend   <= '0;
      dp_divisor    <= '0;
      rsp_id        <= '0;
      rsp_remainder <= '0;
      rsp_divzero   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && grant) begin
        rsp_id <= idx;
        ptr_q  <= (int'(idx) == NREQ - 1) ? '0 : idx + 1'b1;
        // zero divisor bypasses the datapath entirely
        if (sel_ds == '0) begin
          rsp_remainder <= sel_dd;
          rsp_divzero   <= 1'b1;
        end else begin
          dp_dividend <= sel_dd;
          dp_divisor  <= sel_ds;
        end
      end
      if (state_q == S_ISSUE) cnt_q <= CNTW'(LAT - 1);
      if (state_q == S_WAIT) begin
        if (cnt_q == '0) begin
          rsp_remainder <= dp_remainder;
          rsp_divzero   <= 1'b0;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_remainder_scheduler.sv
// tb_remainder_scheduler: directed checks of the scheduler with
// LAT=1, LAT=4 and LAT=15 instances and a latency-exact datapath.
module tb_remainder_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  sel = 2'd0;
  logic [3:0]  rv  = '0;
  logic [79:0] rdd = '0;
  logic [79:0] rds = '0;
  logic        rr  = 1'b0;

  logic [3:0]  o_rdy  [3];
  logic [19:0] o_dpdd [3];
  logic [19:0] o_dpds [3];
  logic        o_dps  [3];
  logic [19:0] o_dprem[3];
  logic        o_rspv [3];
  logic [1:0]  o_rspid[3];
  logic [19:0] o_rem  [3];
  logic        o_dz   [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int L = (k == 0) ? 1 : (k == 1) ? 4 : 15;
    logic [19:0] ma = '0;
    logic [19:0] mb = 20'd1;
    logic [3:0]  mc = '0;

    remainder_scheduler #(.NREQ(4), .W(20), .LAT(L), .IDW(2)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    ((sel == 2'(k)) ? rv : 4'b0),
      .req_ready    (o_rdy[k]),
      .req_dividend (rdd),
      .req_divisor  (rds),
      .dp_dividend  (o_dpdd[k]),
      .dp_divisor   (o_dpds[k]),
      .dp_start     (o_dps[k]),
      .dp_remainder (o_dprem[k]),
      .rsp_valid    (o_rspv[k]),
      .rsp_ready    ((sel == 2'(k)) ? rr : 1'b0),
      .rsp_id       (o_rspid[k]),
      .rsp_remainder(o_rem[k]),
      .rsp_divzero  (o_dz[k])
    );

    // result is only valid exactly L cycles after the start cycle
    always @(posedge clk) begin
      if (o_dps[k]) begin
        ma <= o_dpdd[k];
        mb <= o_dpds[k];
        mc <= 4'(L - 1);
      end else if (mc != 0) begin
        mc <= mc - 4'd1;
      end
    end
    assign o_dprem[k] = (mc == 0 && mb != 0) ? ma % mb : 20'h5A5A5;
  end

  logic [3:0]  c_rdy;
  logic [19:0] c_dpdd, c_dpds, c_rem;
  logic        c_dps, c_rspv, c_dz;
  logic [1:0]  c_id;
  assign c_rdy  = o_rdy[sel];
  assign c_dpdd = o_dpdd[sel];
  assign c_dpds = o_dpds[sel];
  assign c_dps  = o_dps[sel];
  assign c_rspv = o_rspv[sel];
  assign c_id   = o_rspid[sel];
  assign c_rem  = o_rem[sel];
  assign c_dz   = o_dz[sel];

  task automatic test_reset();
    logic [84:0] got;
    rst = 1'b1; rv = '0; rr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sel = 2'(k);
      #1;
      got = {c_rdy, c_dps, c_dpdd, c_dpds, c_rspv, c_id, c_rem, c_dz};
      n_cmp++;
      if (got !== '0) begin
        n_bad++;
        $display("FAIL reset_state[%0d]: got %h want 0", k, got);
      end
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    sel = 2'd0; rr = 1'b1;
    @(negedge clk);
    rv = 4'b0001; rdd[0 +: 20] = 20'd50; rds[0 +: 20] = 20'd7;
    #1;
    n_cmp++;
    if (c_rdy !== 4'b0001) begin
      n_bad++; $display("FAIL single_grant: got %b want 0001", c_rdy);
    end
    @(negedge clk); rv = '0; #1;
    n_cmp++;
    if ({c_dps, c_dpdd, c_dpds} !== {1'b1, 20'd50, 20'd7}) begin
      n_bad++;
      $display("FAIL single_issue: got %b %0d %0d want 1 50 7",
               c_dps, c_dpdd, c_dpds);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (c_rspv !== 1'b0) begin
      n_bad++; $display("FAIL single_early: got %b want 0", c_rspv);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({c_rspv, c_id, c_rem, c_dz} !== {1'b1, 2'd0, 20'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL single_rsp: got v%b id%0d r%0d z%b want v1 id0 r1 z0",
               c_rspv, c_id, c_rem, c_dz);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (c_rspv !== 1'b0) begin
      n_bad++; $display("FAIL single_drop: got %b want 0", c_rspv);
    end
  endtask

  task automatic test_contention();
    int          exp_id [5] = '{0, 1, 2, 3, 0};
    int          exp_rem[5] = '{9, 0, 0, 3, 1};
    int          got_id [5] = '{-1, -1, -1, -1, -1};
    logic [19:0] got_rem[5] = '{0, 0, 0, 0, 0};
    int          nr = 0;
    logic        first0 = 1'b1;
    logic        pend0 = 1'b0;
    logic [3:0]  clr = '0;
    sel = 2'd0; rr = 1'b1;
    @(negedge clk);
    rdd = {20'd19, 20'd20, 20'd10, 20'd100};
    rds = {20'd4, 20'd20, 20'd2, 20'd13};
    rv = 4'b1111;
    for (int c = 0; c < 80 && nr < 5; c++) begin
      if (c != 0) @(negedge clk);
      rv = rv & ~clr; clr = '0;
      if (pend0) begin
        rdd[0 +: 20] = 20'd9; rds[0 +: 20] = 20'd4; pend0 = 1'b0;
      end
      #1;
      if (c_rdy[0] && first0) begin
        first0 = 1'b0; pend0 = 1'b1;
      end else begin
        clr = c_rdy;
      end
      if (c_rspv && rr) begin
        got_id[nr] = int'(c_id); got_rem[nr] = c_rem; nr++;
      end
    end
    rv = '0;
    n_cmp++;
    if (nr !== 5) begin
      n_bad++; $display("FAIL cont_count: got %0d want 5", nr);
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (got_id[i] !== exp_id[i]) begin
        n_bad++;
        $display("FAIL cont_id[%0d]: got %0d want %0d", i, got_id[i], exp_id[i]);
      end
      n_cmp++;
      if (got_rem[i] !== 20'(exp_rem[i])) begin
        n_bad++;
        $display("FAIL cont_rem[%0d]: got %0d want %0d", i, got_rem[i], exp_rem[i]);
      end
    end
  endtask

  task automatic test_divzero();
    logic starts;
    sel = 2'd0; rr = 1'b1;
    @(negedge clk);
    rv = 4'b0100; rdd[40 +: 20] = 20'd37; rds[40 +: 20] = 20'd0;
    #1;
    starts = c_dps;
    n_cmp++;
    if (c_rdy !== 4'b0100) begin
      n_bad++; $display("FAIL dz_grant: got %b want 0100", c_rdy);
    end
    @(negedge clk); rv = '0; #1;
    starts |= c_dps;
    n_cmp++;
    if ({c_rspv, c_id, c_rem, c_dz} !== {1'b1, 2'd2, 20'd37, 1'b1}) begin
      n_bad++;
      $display("FAIL dz_rsp: got v%b id%0d r%0d z%b want v1 id2 r37 z1",
               c_rspv, c_id, c_rem, c_dz);
    end
    repeat (3) begin
      @(negedge clk); #1; starts |= c_dps;
    end
    n_cmp++;
    if (starts !== 1'b0) begin
      n_bad++; $display("FAIL dz_no_start: got %b want 0", starts);
    end
  endtask

  task automatic test_back_pressure();
    logic [23:0] snap;
    logic        stable = 1'b1;
    logic [3:0]  rdy_seen = '0;
    int          n = 0;
    sel = 2'd0; rr = 1'b0;
    @(negedge clk);
    rv = 4'b0010; rdd[20 +: 20] = 20'd1000; rds[20 +: 20] = 20'd33;
    #1;
    n_cmp++;
    if (c_rdy !== 4'b0010) begin
      n_bad++; $display("FAIL bp_grant: got %b want 0010", c_rdy);
    end
    @(negedge clk);
    rv = 4'b1000; rdd[60 +: 20] = 20'd5; rds[60 +: 20] = 20'hFFFFF;
    @(negedge clk);
    @(negedge clk); #1;
    snap = {c_rspv, c_id, c_rem, c_dz};
    n_cmp++;
    if (snap !== {1'b1, 2'd1, 20'd10, 1'b0}) begin
      n_bad++; $display("FAIL bp_rsp: got %h want %h", snap, {1'b1, 2'd1, 20'd10, 1'b0});
    end
    repeat (5) begin
      @(negedge clk); #1;
      if ({c_rspv, c_id, c_rem, c_dz} !== snap) stable = 1'b0;
      rdy_seen |= c_rdy;
    end
    n_cmp++;
    if (stable !== 1'b1) begin
      n_bad++; $display("FAIL bp_hold: got %b want 1", stable);
    end
    n_cmp++;
    if (rdy_seen !== 4'b0000) begin
      n_bad++; $display("FAIL bp_no_grant: got %b want 0000", rdy_seen);
    end
    @(negedge clk); rr = 1'b1; #1;
    @(negedge clk); #1;
    n_cmp++;
    if ({c_rspv, c_rdy} !== {1'b0, 4'b1000}) begin
      n_bad++; $display("FAIL bp_release: got v%b rdy%b want v0 rdy1000", c_rspv, c_rdy);
    end
    @(negedge clk); rv = '0; #1;
    while (!c_rspv && n < 20) begin
      @(negedge clk); #1; n++;
    end
    n_cmp++;
    if ({c_rspv, c_id, c_rem, c_dz} !== {1'b1, 2'd3, 20'd5, 1'b0}) begin
      n_bad++;
      $display("FAIL bp_maxdiv: got v%b id%0d r%0d z%b want v1 id3 r5 z0",
               c_rspv, c_id, c_rem, c_dz);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [84:0] got;
    logic        stale = 1'b0;
    int          n = 0;
    sel = 2'd1; rr = 1'b1;
    @(negedge clk);
    rv = 4'b0001; rdd[0 +: 20] = 20'd50; rds[0 +: 20] = 20'd7;
    #1;
    @(negedge clk); rv = '0;
    @(negedge clk);
    @(negedge clk); #1;
    rst = 1'b1; #1;
    got = {c_rdy, c_dps, c_dpdd, c_dpds, c_rspv, c_id, c_rem, c_dz};
    n_cmp++;
    if (got !== '0) begin
      n_bad++; $display("FAIL mid_reset: got %h want 0", got);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk); #1; stale |= c_rspv;
    end
    n_cmp++;
    if (stale !== 1'b0) begin
      n_bad++; $display("FAIL mid_stale: got %b want 0", stale);
    end
    @(negedge clk);
    rv = 4'b0100; rdd[40 +: 20] = 20'hFFFFF; rds[40 +: 20] = 20'd1;
    #1;
    @(negedge clk); rv = '0; #1; n = 1;
    while (!c_rspv && n < 30) begin
      @(negedge clk); #1; n++;
    end
    n_cmp++;
    if (n !== 6) begin
      n_bad++; $display("FAIL mid_latency: got %0d want 6", n);
    end
    n_cmp++;
    if ({c_rspv, c_id, c_rem, c_dz} !== {1'b1, 2'd2, 20'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL mid_rsp: got v%b id%0d r%0d z%b want v1 id2 r0 z0",
               c_rspv, c_id, c_rem, c_dz);
    end
  endtask

  task automatic test_lat15();
    logic early = 1'b0;
    sel = 2'd2; rr = 1'b1;
    @(negedge clk);
    rv = 4'b0010; rdd[20 +: 20] = 20'd123456; rds[20 +: 20] = 20'd1000;
    #1;
    n_cmp++;
    if (c_rdy !== 4'b0010) begin
      n_bad++; $display("FAIL l15_grant: got %b want 0010", c_rdy);
    end
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1) rv = '0;
      #1; early |= c_rspv;
    end
    n_cmp++;
    if (early !== 1'b0) begin
      n_bad++; $display("FAIL l15_early: got %b want 0", early);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({c_rspv, c_id, c_rem, c_dz} !== {1'b1, 2'd1, 20'd456, 1'b0}) begin
      n_bad++;
      $display("FAIL l15_rsp: got v%b id%0d r%0d z%b want v1 id1 r456 z0",
               c_rspv, c_id, c_rem, c_dz);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset();
    test_contention();
    test_divzero();
    test_back_pressure();
    test_reset_mid_op();
    test_lat15();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
